// File: rtl/bandai2003_mapper_gen2.sv
// Bandai 2003 cartridge mapper: key-address unlock FSM with serial bitstream
// output, plus a bank of host-writable registers that open only once unlocked.
module bandai2003_mapper_gen2 #(
  parameter int                NUM_BANKS  = 4,
  parameter logic [7:0]        BANK_BASE  = 8'hC0,
  parameter logic [7:0]        KEY0       = 8'h5A,
  parameter logic [7:0]        KEY1       = 8'hA5,
  parameter int                BS_LEN     = 18,
  parameter logic [BS_LEN-1:0] BS_PATTERN = 18'h05140,
  parameter logic [7:0]        BANK_RST   = 8'hFF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   CEn,
  input  logic                   SSn,
  input  logic                   WEn,
  input  logic                   OEn,
  input  logic [7:0]             ADDR,
  inout  wire  [7:0]             DQ,
  output logic                   SO,
  output logic                   LOCKED,
  output logic [NUM_BANKS*8-1:0] BANK
);

  typedef enum logic [1:0] {
    WAIT_K0  = 2'd0,
    WAIT_K1  = 2'd1,
    SHIFT    = 2'd2,
    UNLOCKED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BS_LEN-1:0] sr_q, sr_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              locked_q, locked_d;
  logic [7:0]        bank_q [NUM_BANKS];
  logic [7:0]        bank_d [NUM_BANKS];

  logic [8:0]        addr_ext_s, base_ext_s, lim_ext_s;
  logic [7:0]        idx_s, rd_data_s;
  logic              sel_s, rd_s, wr_s;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      WAIT_K0: begin
        if (ADDR == KEY0) state_d = WAIT_K1;
        else              state_d = WAIT_K0;
      end
      WAIT_K1: begin
        if (ADDR == KEY1) begin
          state_d = SHIFT;
          sr_d    = BS_PATTERN;
          cnt_d   = 7'd0;
        end else if (ADDR == KEY0) begin
          state_d = WAIT_K1;
        end else begin
          state_d = WAIT_K0;
        end
      end
      SHIFT: begin
        sr_d  = {1'b1, sr_q[BS_LEN-1:1]};
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'(BS_LEN - 1)) state_d = UNLOCKED;
        else                         state_d = SHIFT;
      end
      UNLOCKED: state_d = UNLOCKED;
      default: begin
        state_d = WAIT_K0;
        sr_d    = {BS_LEN{1'b1}};
        cnt_d   = 7'd0;
      end
    endcase
    locked_d = (state_d != UNLOCKED);
  end

  // Range check done at 9 bits so a window touching 8'hFF cannot wrap to 0.
  always_comb begin
    addr_ext_s = {1'b0, ADDR};
    base_ext_s = {1'b0, BANK_BASE};
    lim_ext_s  = base_ext_s + 9'(NUM_BANKS);
    idx_s      = ADDR - BANK_BASE;
    sel_s      = (!CEn || !SSn) && (addr_ext_s >= base_ext_s) && (addr_ext_s < lim_ext_s);
    rd_s       = sel_s && !OEn && WEn;
    wr_s       = sel_s && !WEn && OEn;
  end

  // Writes use the current lock state, so the completing edge still rejects them.
  always_comb begin
    rd_data_s = 8'h00;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (sel_s && (idx_s == 8'(i))) begin
        rd_data_s = bank_q[i];
        if (wr_s && !locked_q) bank_d[i] = DQ;
        else                   bank_d[i] = bank_q[i];
      end else begin
        bank_d[i] = bank_q[i];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= WAIT_K0;
      sr_q     <= {BS_LEN{1'b1}};
      cnt_q    <= 7'd0;
      locked_q <= 1'b1;
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= BANK_RST;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      for (int i = 0; i < NUM_BANKS; i++) bank_q[i] <= bank_d[i];
    end
  end

  always_comb begin
    BANK = {(NUM_BANKS*8){1'b0}};
    for (int i = 0; i < NUM_BANKS; i++) BANK[i*8 +: 8] = bank_q[i];
  end

  assign SO     = sr_q[0];
  assign LOCKED = locked_q;
  assign DQ     = (rd_s && !locked_q) ? rd_data_s : {8{1'bz}};

endmodule
